// File: rtl/issue_scoreboard_pkg.sv
// Shared instruction types, register-use decode and opcode constants for the
// decode/issue scoreboard.
package types;

  typedef logic [31:0] instr_t;
  typedef logic [4:0]  rnum_t;
  typedef logic [4:0]  opcode_t;

  // Field order mirrors the instruction bit layout, so the packed struct equals the raw word.
  typedef struct packed {
    logic [6:0] funct7;
    rnum_t      rs2;
    rnum_t      rs1;
    logic [2:0] funct3;
    rnum_t      rd;
    logic [6:0] opcode;
  } instr_fields_t;

  typedef struct packed {
    logic rs1_en;
    logic rs2_en;
    logic rd_en;
  } reg_use_t;

  localparam opcode_t OPC_LOAD     = 5'b00000;
  localparam opcode_t OPC_MISC_MEM = 5'b00011;
  localparam opcode_t OPC_OP_IMM   = 5'b00100;
  localparam opcode_t OPC_AUIPC    = 5'b00101;
  localparam opcode_t OPC_STORE    = 5'b01000;
  localparam opcode_t OPC_OP       = 5'b01100;
  localparam opcode_t OPC_LUI      = 5'b01101;
  localparam opcode_t OPC_BRANCH   = 5'b11000;
  localparam opcode_t OPC_JALR     = 5'b11001;
  localparam opcode_t OPC_JAL      = 5'b11011;
  localparam opcode_t OPC_SYSTEM   = 5'b11100;

  function automatic instr_fields_t instr_fields(instr_t i);
    instr_fields_t f;
    f.funct7 = i[31:25];
    f.rs2    = i[24:20];
    f.rs1    = i[19:15];
    f.funct3 = i[14:12];
    f.rd     = i[11:7];
    f.opcode = i[6:0];
    return f;
  endfunction

  // MISC-MEM and unrecognised opcodes touch no registers.
  function automatic reg_use_t reg_use(opcode_t opc);
    reg_use_t u;
    u = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_en: 1'b0};
    case (opc)
      OPC_OP:                                   u = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_en: 1'b1};
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: u = '{rs1_en: 1'b1, rs2_en: 1'b0, rd_en: 1'b1};
      OPC_BRANCH, OPC_STORE:                    u = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_en: 1'b0};
      OPC_LUI, OPC_AUIPC, OPC_JAL:              u = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_en: 1'b1};
      default:                                  u = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_en: 1'b0};
    endcase
    return u;
  endfunction

endpackage

// File: rtl/issue_scoreboard_counters.sv
// Per-register outstanding-write counters: one increment from issue, WB_PORTS
// decrements from writeback, saturating at zero on underflow.
module sb_counters
  import types::*;
#(
  parameter int WB_PORTS = 2,
  parameter int CNT_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_en_i,
  input  rnum_t                 inc_rd_i,
  input  logic [WB_PORTS-1:0]   wb_valid_i,
  input  logic [WB_PORTS*5-1:0] wb_rd_i,
  output logic [31:0]           busy_o,
  output logic [31:0]           full_o,
  output logic                  underflow_o
);

  localparam int DW = $clog2(WB_PORTS + 1);
  localparam int NW = CNT_W + DW + 1;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [DW-1:0]    ndec  [32];
  logic [NW-1:0]    up    [32];
  logic [NW-1:0]    dn    [32];
  logic [31:0]      uf;

  // x0 is hard-wired: it never counts writes and ignores writebacks.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      ndec[r] = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_i[p] && (wb_rd_i[p*5 +: 5] == r[4:0]) && (r != 0)) begin
          ndec[r] = ndec[r] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      up[r]    = NW'(cnt_q[r]) + NW'(inc_en_i && (inc_rd_i == r[4:0]) && (r != 0));
      dn[r]    = NW'(ndec[r]);
      uf[r]    = dn[r] > up[r];
      cnt_d[r] = uf[r] ? '0 : CNT_W'(up[r] - dn[r]);
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      busy_o[r] = cnt_q[r] != '0;
      full_o[r] = cnt_q[r] == '1;
    end
  end

  assign underflow_o = |uf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode/issue slot: holds one instruction and offers it to execute only when
// none of its source registers has a pending write and its destination is not saturated.
module issue_scoreboard
  import types::*;
#(
  parameter int WB_PORTS = 2,
  parameter int CNT_W    = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_instr,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [31:0]                        out_instr,
  output logic [$bits(instr_fields_t)-1:0]   out_fields,
  input  logic [WB_PORTS-1:0]                wb_valid,
  input  logic [WB_PORTS*5-1:0]              wb_rd,
  input  logic                               flush,
  output logic [31:0]                        busy,
  output logic                               sb_err
);

  logic          slot_valid_q, slot_valid_d;
  instr_t        slot_instr_q, slot_instr_d;
  logic          sb_err_q, sb_err_d;

  instr_fields_t slot_fields;
  reg_use_t      use_w;
  logic          rs1_used, rs2_used, rd_used;
  logic          hazard, fire, accept;
  logic [31:0]   full;
  logic          underflow;

  assign slot_fields = instr_fields(slot_instr_q);
  assign use_w       = reg_use(slot_fields.opcode[6:2]);
  assign rs1_used    = use_w.rs1_en && (slot_fields.rs1 != '0);
  assign rs2_used    = use_w.rs2_en && (slot_fields.rs2 != '0);
  assign rd_used     = use_w.rd_en  && (slot_fields.rd  != '0);

  // Hazards look only at registered counters; a writeback releases the slot one cycle later.
  assign hazard = (rs1_used && busy[slot_fields.rs1]) ||
                  (rs2_used && busy[slot_fields.rs2]) ||
                  (rd_used  && full[slot_fields.rd]);

  assign out_valid  = slot_valid_q && !hazard && !flush;
  assign fire       = out_valid && out_ready;
  assign in_ready   = !flush && (!slot_valid_q || fire);
  assign accept     = in_valid && in_ready;

  assign out_instr  = slot_instr_q;
  assign out_fields = slot_fields;
  assign sb_err     = sb_err_q;

  sb_counters #(
    .WB_PORTS (WB_PORTS),
    .CNT_W    (CNT_W)
  ) u_counters (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_en_i    (fire && rd_used),
    .inc_rd_i    (slot_fields.rd),
    .wb_valid_i  (wb_valid),
    .wb_rd_i     (wb_rd),
    .busy_o      (busy),
    .full_o      (full),
    .underflow_o (underflow)
  );

  // Flush wins over everything; otherwise a new accept refills the slot even as it issues.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    if (flush) begin
      slot_valid_d = 1'b0;
    end else if (accept) begin
      slot_valid_d = 1'b1;
      slot_instr_d = in_instr;
    end else if (fire) begin
      slot_valid_d = 1'b0;
    end
    sb_err_d = sb_err_q | underflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      slot_instr_q <= '0;
      sb_err_q     <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
      sb_err_q     <= sb_err_d;
    end
  end

endmodule
